axi_tid_order_tracker: RTL and testbench

//  Slave-NI transaction ordering tracker, successor of the per-TID reordering unit.
//  Per AXI TID: pending count, bound destination and a 3-state drain FSM.

---
 rtl/axi_tid_order_tracker.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_tid_order_tracker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tid_order_tracker.sv
// Slave-NI transaction ordering tracker.
// Keeps, per AXI TID, an outstanding count, the destination the TID is bound to and a
// three-state drain FSM, so responses for one TID can never return out of order across
// destinations. Adds per-destination and global outstanding caps and, for overlapping
// address maps, round-robin or least-loaded destination selection.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       request presented this cycle
//   req_tid         binary TID of the request
//   req_avail_dsts  destinations that can serve the request (multi-hot only when overlapping)
//   req_qualifies   request may inject this cycle (combinational)
//   req_dst_final   binary destination chosen (combinational)
//   resp_valid      one response returning
//   resp_tid        binary TID of the response
//   total_pending   registered global outstanding count
//   err_underflow   sticky flag: response seen for a TID with nothing outstanding
module axi_tid_order_tracker #(
  parameter int unsigned TRANSACTION_IDS      = 16,
  parameter int unsigned EXT_SLAVES           = 4,
  parameter int unsigned OVERLAPPING_ADDRS    = 0,
  parameter int unsigned MAX_PENDING_SAME_DST = 16,
  parameter int unsigned MAX_PENDING_DST      = 32,
  parameter int unsigned MAX_PENDING_TOTAL    = 64,
  parameter int unsigned LB_MODE              = 0,
  parameter int unsigned MASTER_ID            = 0,
  localparam int unsigned TW   = (TRANSACTION_IDS > 1) ? $clog2(TRANSACTION_IDS) : 1,
  localparam int unsigned SW   = (EXT_SLAVES > 1) ? $clog2(EXT_SLAVES) : 1,
  localparam int unsigned TOTW = $clog2(MAX_PENDING_TOTAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [TW-1:0]         req_tid,
  input  logic [EXT_SLAVES-1:0] req_avail_dsts,
  output logic                  req_qualifies,
  output logic [SW-1:0]         req_dst_final,
  input  logic                  resp_valid,
  input  logic [TW-1:0]         resp_tid,
  output logic [TOTW-1:0]       total_pending,
  output logic                  err_underflow
);

  localparam int unsigned PW = $clog2(MAX_PENDING_SAME_DST + 1);
  localparam int unsigned DW = $clog2(MAX_PENDING_DST + 1);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} tid_st_e;

  tid_st_e         st_q       [TRANSACTION_IDS];
  tid_st_e         st_d       [TRANSACTION_IDS];
  logic [PW-1:0]   pend_q     [TRANSACTION_IDS];
  logic [PW-1:0]   pend_d     [TRANSACTION_IDS];
  logic [SW-1:0]   bound_q    [TRANSACTION_IDS];
  logic [SW-1:0]   bound_d    [TRANSACTION_IDS];
  logic [DW-1:0]   dst_pend_q [EXT_SLAVES];
  logic [DW-1:0]   dst_pend_d [EXT_SLAVES];
  logic [TOTW-1:0] total_q, total_d;
  logic [SW-1:0]   rr_q, rr_d;
  logic            err_q, err_d;

  logic [EXT_SLAVES-1:0] dst_full;
  logic [EXT_SLAVES-1:0] cand;
  logic [SW-1:0]         idle_dst, chosen, scan_idx;
  logic                  idle_ok, tid_ok, qual_raw;
  logic [DW-1:0]         best_cnt;
  logic                  incr, decr;
  logic [SW-1:0]         resp_dst;

  always_comb begin
    for (int d = 0; d < EXT_SLAVES; d++) begin
      dst_full[d] = dst_pend_q[d] >= DW'(MAX_PENDING_DST);
    end
  end

  // Destination for a TID that is not yet bound.
  always_comb begin
    idle_dst = '0;
    idle_ok  = 1'b0;
    best_cnt = '1;
    scan_idx = '0;
    cand     = req_avail_dsts & ~dst_full;
    if (OVERLAPPING_ADDRS == 0) begin
      for (int d = 0; d < EXT_SLAVES; d++) begin
        if (req_avail_dsts[d]) begin
          idle_dst = SW'(d);
          idle_ok  = 1'b1;
        end
      end
    end else begin
      // Scan starting at the RR pointer; strict less-than keeps the earliest in RR order
      // on load ties.
      for (int i = 0; i < EXT_SLAVES; i++) begin
        scan_idx = SW'((int'(rr_q) + i) % EXT_SLAVES);
        if (cand[scan_idx]) begin
          if (LB_MODE == 0) begin
            if (!idle_ok) begin
              idle_dst = scan_idx;
              idle_ok  = 1'b1;
            end
          end else if (!idle_ok || (dst_pend_q[scan_idx] < best_cnt)) begin
            idle_dst = scan_idx;
            idle_ok  = 1'b1;
            best_cnt = dst_pend_q[scan_idx];
          end
        end
      end
    end
  end

  always_comb begin
    chosen = bound_q[req_tid];
    tid_ok = 1'b0;
    case (st_q[req_tid])
      StIdle: begin
        chosen = idle_dst;
        tid_ok = idle_ok;
      end
      StActive: begin
        tid_ok = req_avail_dsts[bound_q[req_tid]] &&
                 (pend_q[req_tid] < PW'(MAX_PENDING_SAME_DST));
      end
      default: tid_ok = 1'b0;
    endcase
    qual_raw = tid_ok && !dst_full[chosen] && (total_q < TOTW'(MAX_PENDING_TOTAL));
  end

  assign req_qualifies = req_valid & qual_raw;
  assign req_dst_final = req_valid ? chosen : '0;
  assign total_pending = total_q;
  assign err_underflow = err_q;

  assign incr     = req_qualifies;
  assign decr     = resp_valid && (pend_q[resp_tid] != '0);
  assign resp_dst = bound_q[resp_tid];

  always_comb begin
    for (int t = 0; t < TRANSACTION_IDS; t++) begin
      logic inc_t, dec_t;
      st_d[t]    = st_q[t];
      pend_d[t]  = pend_q[t];
      bound_d[t] = bound_q[t];
      inc_t = incr && (req_tid == TW'(t));
      dec_t = decr && (resp_tid == TW'(t));
      // A request that would move an active TID elsewhere parks it until drained.
      if (req_valid && (req_tid == TW'(t)) && (st_q[t] == StActive) &&
          !req_avail_dsts[bound_q[t]]) begin
        st_d[t] = StDrain;
      end
      if (inc_t && !dec_t) begin
        pend_d[t] = pend_q[t] + 1'b1;
        if (st_q[t] == StIdle) begin
          st_d[t]    = StActive;
          bound_d[t] = req_dst_final;
        end
      end else if (dec_t && !inc_t) begin
        pend_d[t] = pend_q[t] - 1'b1;
        if (pend_q[t] == PW'(1)) begin
          st_d[t] = StIdle;
        end
      end
    end

    for (int d = 0; d < EXT_SLAVES; d++) begin
      logic inc_d, dec_d;
      dst_pend_d[d] = dst_pend_q[d];
      inc_d = incr && (req_dst_final == SW'(d));
      dec_d = decr && (resp_dst == SW'(d));
      if (inc_d && !dec_d) begin
        dst_pend_d[d] = dst_pend_q[d] + 1'b1;
      end else if (dec_d && !inc_d) begin
        dst_pend_d[d] = dst_pend_q[d] - 1'b1;
      end
    end

    total_d = total_q;
    if (incr && !decr) begin
      total_d = total_q + 1'b1;
    end else if (decr && !incr) begin
      total_d = total_q - 1'b1;
    end

    rr_d = rr_q;
    if (incr) begin
      rr_d = (req_dst_final == SW'(EXT_SLAVES - 1)) ? '0 : req_dst_final + 1'b1;
    end

    err_d = err_q | (resp_valid && (pend_q[resp_tid] == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < TRANSACTION_IDS; t++) begin
        st_q[t]    <= StIdle;
        pend_q[t]  <= '0;
        bound_q[t] <= '0;
      end
      for (int d = 0; d < EXT_SLAVES; d++) begin
        dst_pend_q[d] <= '0;
      end
      total_q <= '0;
      rr_q    <= SW'(MASTER_ID % EXT_SLAVES);
      err_q   <= 1'b0;
    end else begin
      for (int t = 0; t < TRANSACTION_IDS; t++) begin
        st_q[t]    <= st_d[t];
        pend_q[t]  <= pend_d[t];
        bound_q[t] <= bound_d[t];
      end
      for (int d = 0; d < EXT_SLAVES; d++) begin
        dst_pend_q[d] <= dst_pend_d[d];
      end
      total_q <= total_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (total_q <= TOTW'(MAX_PENDING_TOTAL))
        else $fatal(1, "total_pending above cap");
      for (int d = 0; d < EXT_SLAVES; d++) begin
        assert (dst_pend_q[d] <= DW'(MAX_PENDING_DST))
          else $fatal(1, "dst_pending above cap");
      end
      for (int t = 0; t < TRANSACTION_IDS; t++) begin
        assert (pend_q[t] <= PW'(MAX_PENDING_SAME_DST))
          else $fatal(1, "pending_tid above cap");
        assert ((st_q[t] == StIdle) == (pend_q[t] == '0))
          else $fatal(1, "TID state disagrees with pending count");
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_tid_order_tracker.sv
// Directed bench for axi_tid_order_tracker: a default-parameter instance for ordering,
// caps, underflow and reset, and an overlapping least-loaded instance for destination choice.
module tb_axi_tid_order_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       req_valid = 1'b0;
  logic [3:0] req_tid = '0;
  logic [3:0] req_avail_dsts = '0;
  logic       req_qualifies;
  logic [1:0] req_dst_final;
  logic       resp_valid = 1'b0;
  logic [3:0] resp_tid = '0;
  logic [6:0] total_pending;
  logic       err_underflow;

  logic       lb_req_valid = 1'b0;
  logic [3:0] lb_req_tid = '0;
  logic [3:0] lb_req_avail_dsts = '0;
  logic       lb_req_qualifies;
  logic [1:0] lb_req_dst_final;
  logic [6:0] lb_total_pending;
  logic       lb_err_underflow;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  axi_tid_order_tracker u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_tid        (req_tid),
    .req_avail_dsts (req_avail_dsts),
    .req_qualifies  (req_qualifies),
    .req_dst_final  (req_dst_final),
    .resp_valid     (resp_valid),
    .resp_tid       (resp_tid),
    .total_pending  (total_pending),
    .err_underflow  (err_underflow)
  );

  axi_tid_order_tracker #(
    .OVERLAPPING_ADDRS (1),
    .LB_MODE           (1)
  ) u_lb (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (lb_req_valid),
    .req_tid        (lb_req_tid),
    .req_avail_dsts (lb_req_avail_dsts),
    .req_qualifies  (lb_req_qualifies),
    .req_dst_final  (lb_req_dst_final),
    .resp_valid     (1'b0),
    .resp_tid       (4'd0),
    .total_pending  (lb_total_pending),
    .err_underflow  (lb_err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks sample 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] tid, input logic [3:0] avail);
    req_valid      = 1'b1;
    req_tid        = tid;
    req_avail_dsts = avail;
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    resp_valid = 1'b0;
  endtask

  task automatic lb_burst(input logic [3:0] tid, input logic [3:0] avail, input int n);
    lb_req_valid      = 1'b1;
    lb_req_tid        = tid;
    lb_req_avail_dsts = avail;
    for (int i = 0; i < n; i++) cyc();
    lb_req_valid = 1'b0;
  endtask

  task automatic burst(input logic [3:0] tid, input logic [3:0] avail, input int n);
    req(tid, avail);
    for (int i = 0; i < n; i++) cyc();
    idle();
  endtask

  initial begin
    #12;
    rst_n = 1'b1;
    cyc();

    // Reset state and idle outputs
    #1;
    chk("rst_total", 32'(total_pending), 0);
    chk("rst_err", 32'(err_underflow), 0);
    chk("idle_qual", 32'(req_qualifies), 0);
    chk("idle_dst", 32'(req_dst_final), 0);

    // T3: least-loaded with RR tie-break; loads dst0..3 = 7,2,2,5 and RR pointer ends at 2
    lb_burst(4'd0, 4'b0001, 7);
    lb_burst(4'd3, 4'b1000, 5);
    lb_burst(4'd2, 4'b0100, 2);
    lb_burst(4'd1, 4'b0010, 2);
    chk("lb_total", 32'(lb_total_pending), 16);
    lb_req_valid      = 1'b1;
    lb_req_tid        = 4'd4;
    lb_req_avail_dsts = 4'b1111;
    #1;
    chk("lb_tie_qual", 32'(lb_req_qualifies), 1);
    chk("lb_tie_dst", 32'(lb_req_dst_final), 2);
    cyc();
    // dst2 now 3, pointer 3: dst1 is the unique minimum
    lb_req_tid = 4'd5;
    #1;
    chk("lb_min_dst", 32'(lb_req_dst_final), 1);
    lb_req_valid = 1'b0;

    // T1: 16 requests fill the per-TID cap
    req(4'd3, 4'b0100);
    #1;
    chk("t1_first_qual", 32'(req_qualifies), 1);
    chk("t1_first_dst", 32'(req_dst_final), 2);
    for (int i = 0; i < 16; i++) cyc();
    #1;
    chk("t1_17th_qual", 32'(req_qualifies), 0);
    chk("t1_pend_tid3", 32'(u_dut.pend_q[3]), 16);
    chk("t1_total", 32'(total_pending), 16);
    idle();

    // T2: TID1 bound to dst0, then asked for dst1 -> drain until empty
    burst(4'd1, 4'b0001, 2);
    chk("t2_total_after2", 32'(total_pending), 18);
    req(4'd1, 4'b0010);
    #1;
    chk("t2_mismatch_qual", 32'(req_qualifies), 0);
    cyc();
    req(4'd1, 4'b0001);
    #1;
    chk("t2_drain_blocks", 32'(req_qualifies), 0);
    idle();
    resp_valid = 1'b1;
    resp_tid   = 4'd1;
    cyc();
    chk("t2_resp1_total", 32'(total_pending), 17);
    cyc();
    idle();
    chk("t2_resp2_total", 32'(total_pending), 16);
    req(4'd1, 4'b0010);
    #1;
    chk("t2_requal", 32'(req_qualifies), 1);
    chk("t2_new_dst", 32'(req_dst_final), 1);
    cyc();
    idle();
    chk("t2_total_taken", 32'(total_pending), 17);
    resp_valid = 1'b1;
    resp_tid   = 4'd1;
    cyc();
    idle();
    chk("t2_total_clear", 32'(total_pending), 16);

    // T4: same-TID request and response cancel
    burst(4'd5, 4'b1000, 3);
    chk("t4_total_pre", 32'(total_pending), 19);
    req(4'd5, 4'b1000);
    resp_valid = 1'b1;
    resp_tid   = 4'd5;
    #1;
    chk("t4_qual", 32'(req_qualifies), 1);
    cyc();
    chk("t4_pend_tid5", 32'(u_dut.pend_q[5]), 3);
    chk("t4_total", 32'(total_pending), 19);
    // Different TIDs on the same destination: dst3 count holds at 3
    req(4'd6, 4'b1000);
    cyc();
    idle();
    chk("t4_diff_total", 32'(total_pending), 19);
    chk("t4_diff_dst3", 32'(u_dut.dst_pend_q[3]), 3);
    chk("t4_diff_pend5", 32'(u_dut.pend_q[5]), 2);
    chk("t4_diff_pend6", 32'(u_dut.pend_q[6]), 1);

    // T5: response for a TID with nothing outstanding
    resp_valid = 1'b1;
    resp_tid   = 4'd7;
    cyc();
    idle();
    chk("t5_err", 32'(err_underflow), 1);
    chk("t5_total", 32'(total_pending), 19);
    cyc();
    chk("t5_err_sticky", 32'(err_underflow), 1);

    // Per-destination cap: dst2 reaches 32
    burst(4'd12, 4'b0100, 16);
    chk("dcap_dst2", 32'(u_dut.dst_pend_q[2]), 32);
    req(4'd13, 4'b0100);
    #1;
    chk("dcap_qual", 32'(req_qualifies), 0);
    idle();

    // T6: global cap at 64
    burst(4'd8, 4'b0001, 16);
    burst(4'd9, 4'b0010, 13);
    chk("t6_total", 32'(total_pending), 64);
    req(4'd11, 4'b0001);
    #1;
    chk("t6_cap_qual", 32'(req_qualifies), 0);
    idle();
    resp_valid = 1'b1;
    resp_tid   = 4'd8;
    cyc();
    idle();
    chk("t6_total_63", 32'(total_pending), 63);
    req(4'd11, 4'b0001);
    #1;
    chk("t6_requal", 32'(req_qualifies), 1);
    cyc();
    chk("t6_total_back", 32'(total_pending), 64);
    resp_valid = 1'b1;
    resp_tid   = 4'd9;
    cyc();
    // Asynchronous reset mid-burst, between clock edges
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_total", 32'(total_pending), 0);
    chk("t6_rst_err", 32'(err_underflow), 0);
    chk("t6_rst_pend3", 32'(u_dut.pend_q[3]), 0);
    chk("t6_rst_dst2", 32'(u_dut.dst_pend_q[2]), 0);
    idle();
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
